// File: rtl/cpu_pkg.sv
// Shared CPU definitions: read-arbiter FSM states, default AXI IDs and AXI constants.
package cpu_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned AXI_ID_W   = 4;
    localparam int unsigned BEAT_CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } rd_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Refill command latched at grant time
    typedef struct packed {
        owner_t              owner;
        logic [ADDR_W-1:0]   addr;
    } rd_cmd_t;

    localparam logic [AXI_ID_W-1:0] ID_I_DEF   = 4'd0;
    localparam logic [AXI_ID_W-1:0] ID_D_DEF   = 4'd1;
    localparam logic [1:0]          BURST_INCR = 2'b01;
    localparam logic [2:0]          SIZE_4B    = 3'b010;
    localparam logic [1:0]          RESP_OKAY  = 2'b00;

endpackage

// File: rtl/cache_rd_arbiter_rr_arb2.sv
// Two-way round-robin picker; remembers the last burst owner to break ties.
module rr_arb2
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    input  logic       upd,
    input  owner_t     upd_owner,
    output logic [1:0] grant_c
);

    owner_t last_grant;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant <= OWN_I;
        end else if (upd) begin
            last_grant <= upd_owner;
        end
    end

    // On a tie the side that did not own the previous burst wins
    always_comb begin
        grant_c = req;
        if (req == 2'b11) begin
            grant_c = (last_grant == OWN_I) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/cache_rd_arbiter.sv
// Arbitrates ICache/DCache line refills onto one AXI read port and routes beats back.
module cache_rd_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned         LINE_WORDS = 4,
    parameter logic [AXI_ID_W-1:0] ID_I       = ID_I_DEF,
    parameter logic [AXI_ID_W-1:0] ID_D       = ID_D_DEF
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                icache_rd_req,
    input  logic [ADDR_W-1:0]   icache_rd_addr,
    output logic                icache_rd_rdy,
    output logic                icache_ret_valid,
    output logic                icache_ret_last,
    output logic [DATA_W-1:0]   icache_ret_data,
    input  logic                dcache_rd_req,
    input  logic [ADDR_W-1:0]   dcache_rd_addr,
    output logic                dcache_rd_rdy,
    output logic                dcache_ret_valid,
    output logic                dcache_ret_last,
    output logic [DATA_W-1:0]   dcache_ret_data,
    output logic [AXI_ID_W-1:0] arid,
    output logic [ADDR_W-1:0]   araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic                arvalid,
    input  logic                arready,
    input  logic [AXI_ID_W-1:0] rid,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,
    output logic                rd_err
);

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(LINE_WORDS - 1);

    rd_state_t             state;
    rd_state_t             state_nxt;
    rd_cmd_t               cmd_q;
    logic [BEAT_CNT_W-1:0] cnt_q;
    logic [1:0]            grant_c;
    logic                  burst_done_c;
    logic                  beat_bad_c;

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rstn      (rstn),
        .req       ({dcache_rd_req, icache_rd_req}),
        .upd       (burst_done_c),
        .upd_owner (cmd_q.owner),
        .grant_c   (grant_c)
    );

    assign arid            = (cmd_q.owner == OWN_D) ? ID_D : ID_I;
    assign araddr          = cmd_q.addr;
    assign arlen           = 8'(LINE_WORDS - 1);
    assign arsize          = SIZE_4B;
    assign arburst         = BURST_INCR;
    assign icache_ret_data = rdata;
    assign dcache_ret_data = rdata;

    // Any malformed beat: bad response, foreign ID, or rlast not on the final beat
    assign beat_bad_c = (rresp != RESP_OKAY) || (rid != arid) || (rlast != (cnt_q == LAST_BEAT));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        icache_rd_rdy    = 1'b0;
        dcache_rd_rdy    = 1'b0;
        arvalid          = 1'b0;
        rready           = 1'b0;
        icache_ret_valid = 1'b0;
        icache_ret_last  = 1'b0;
        dcache_ret_valid = 1'b0;
        dcache_ret_last  = 1'b0;
        burst_done_c     = 1'b0;
        case (state)
            S_IDLE: begin
                icache_rd_rdy = grant_c[0];
                dcache_rd_rdy = grant_c[1];
                if (|grant_c) begin
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    icache_ret_valid = (cmd_q.owner == OWN_I);
                    icache_ret_last  = (cmd_q.owner == OWN_I) && rlast;
                    dcache_ret_valid = (cmd_q.owner == OWN_D);
                    dcache_ret_last  = (cmd_q.owner == OWN_D) && rlast;
                    if (rlast) begin
                        state_nxt    = S_IDLE;
                        burst_done_c = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Command latch, beat counter and sticky error flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmd_q  <= '0;
            cnt_q  <= '0;
            rd_err <= 1'b0;
        end else begin
            if ((state == S_IDLE) && (|grant_c)) begin
                cmd_q.owner <= grant_c[1] ? OWN_D : OWN_I;
                cmd_q.addr  <= (grant_c[1] ? dcache_rd_addr : icache_rd_addr) & ~32'h3;
            end
            if ((state == S_ADDR) && arready) begin
                cnt_q <= '0;
            end
            if ((state == S_DATA) && rvalid) begin
                cnt_q <= cnt_q + 4'd1;
                if (beat_bad_c) begin
                    rd_err <= 1'b1;
                end
            end
        end
    end

endmodule
